// File: rtl/irq_prio_encoder_8x3_pkg.sv
// ----------------------------------------------------------------------------
// irq_enc_pkg
// Shared constants, FSM state encoding and a small helper for the 8-to-3
// interrupt request encoder.
//   N_REQ   : number of request lines (fixed at 8)
//   IDX_W   : width of the encoded index (log2(N_REQ))
//   state_t : two-state FSM encoding (IDLE / GRANT)
// Optional feature macro used by the consumers of this package:
//   IRQ_ROUND_ROBIN_EN
// ----------------------------------------------------------------------------
package irq_enc_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef logic [0:0] state_t;
    localparam state_t IDLE  = 1'b0;
    localparam state_t GRANT = 1'b1;

    // One-hot mask for a single request index.
    function automatic logic [N_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] i);
        logic [N_REQ-1:0] one;
        one = N_REQ'(1);
        return one << i;
    endfunction

endpackage

// File: rtl/irq_prio_encoder_8x3_if.sv
// ----------------------------------------------------------------------------
// irq_prio_encoder_8x3_if
// Bundle of request/handshake signals between the request sources / CPU
// control unit (master) and the encoder (slave).
//   req     : request lines (edge-sensitive at the encoder)
//   mask    : 1 = line excluded from selection
//   ack     : consumer accepts current idx (only meaningful while valid=1)
//   clr_ovf : synchronous clear of the overflow flag
//   idx     : encoded index of the granted request
//   valid   : idx is valid and stable
//   pending : current pending register
//   ovf     : sticky overflow flag
// ----------------------------------------------------------------------------
interface irq_prio_encoder_8x3_if;
    import irq_enc_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] mask;
    logic             ack;
    logic             clr_ovf;
    logic [IDX_W-1:0] idx;
    logic             valid;
    logic [N_REQ-1:0] pending;
    logic             ovf;

    modport master (
        output req, mask, ack, clr_ovf,
        input  idx, valid, pending, ovf
    );

    modport slave (
        input  req, mask, ack, clr_ovf,
        output idx, valid, pending, ovf
    );

endinterface

// File: rtl/irq_prio_encoder_8x3_prio_enc.sv
// ----------------------------------------------------------------------------
// prio_enc_8x3
// Combinational wrapping priority encoder: finds the first set bit of vec_i
// at or after position start_i, wrapping from bit 7 back to bit 0.
//   vec_i   : candidate vector
//   start_i : search start position (highest priority)
//   idx_o   : index of the first set bit found
//   any_o   : 1 when vec_i has any bit set
// ----------------------------------------------------------------------------
module prio_enc_8x3
    import irq_enc_pkg::*;
(
    input  logic [N_REQ-1:0] vec_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;

    // Rotate so start_i lands at bit 0, pick the lowest set bit, then add the
    // start back; the 3-bit add wraps naturally modulo 8.
    always_comb begin
        rot = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rot[k] = vec_i[start_i + IDX_W'(k)];
        end
        off = '0;
        for (int k = N_REQ-1; k >= 0; k--) begin
            if (rot[k]) off = IDX_W'(k);
        end
    end

    assign idx_o = start_i + off;
    assign any_o = |vec_i;

endmodule

// File: rtl/irq_prio_encoder_8x3.sv
// ----------------------------------------------------------------------------
// irq_prio_encoder_8x3
// 8-to-3 interrupt request encoder with valid/ack handshake. Captures rising
// edges on the request lines into a pending register, selects the highest
// priority unmasked pending line and holds its index until acknowledged.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : irq_prio_encoder_8x3_if.slave (req/mask/ack/clr_ovf in,
//         idx/valid/pending/ovf out)
// Optional feature: define IRQ_ROUND_ROBIN_EN for rotating priority starting
// after the last granted line; otherwise bit 0 always has highest priority.
// ----------------------------------------------------------------------------
module irq_prio_encoder_8x3
    import irq_enc_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    irq_prio_encoder_8x3_if.slave   bus
);

    logic [N_REQ-1:0] req_q;        // edge-detect history (req delayed by one)
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    state_t           state_q, state_d;
    logic             ovf_q, ovf_d;

    logic [N_REQ-1:0] edge_v, clr_v, cand;
    logic             hs, ovf_set;
    logic [IDX_W-1:0] start, enc_idx;
    logic             enc_any;

`ifdef IRQ_ROUND_ROBIN_EN
    logic [IDX_W-1:0] lg_q;         // last granted index

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     lg_q <= IDX_W'(N_REQ-1);
        else if (hs) lg_q <= idx_q;
    end

    assign start = lg_q + IDX_W'(1);
`else
    assign start = '0;
`endif

    assign cand = pending_q & ~bus.mask;

    prio_enc_8x3 u_enc (
        .vec_i   (cand),
        .start_i (start),
        .idx_o   (enc_idx),
        .any_o   (enc_any)
    );

    always_comb begin
        edge_v    = bus.req & ~req_q;
        hs        = (state_q == GRANT) & bus.ack;
        clr_v     = hs ? idx2onehot(idx_q) : '0;
        // Set has priority over clear on the same bit.
        pending_d = (pending_q & ~clr_v) | edge_v;
        // An edge on a bit being cleared this cycle is a fresh request, not
        // an overflow.
        ovf_set   = |(edge_v & pending_q & ~clr_v);
        ovf_d     = ovf_set | (ovf_q & ~bus.clr_ovf);

        state_d   = state_q;
        idx_d     = idx_q;
        case (state_q)
            IDLE: begin
                if (enc_any) begin
                    idx_d   = enc_idx;
                    state_d = GRANT;
                end
            end
            default: begin
                if (bus.ack) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q     <= '0;
            pending_q <= '0;
            idx_q     <= '0;
            state_q   <= IDLE;
            ovf_q     <= 1'b0;
        end else begin
            req_q     <= bus.req;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            state_q   <= state_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.idx     = idx_q;
    assign bus.valid   = (state_q == GRANT);
    assign bus.pending = pending_q;
    assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_irq_prio_encoder_8x3.sv
// ----------------------------------------------------------------------------
// tb_irq_prio_encoder_8x3
// Directed scenarios followed by random traffic, all checked every cycle
// against a behavioural model of the request encoder. Honours
// IRQ_ROUND_ROBIN_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_irq_prio_encoder_8x3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    irq_prio_encoder_8x3_if bus ();

    irq_prio_encoder_8x3 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit [7:0] m_pend;
    bit [7:0] m_prev;
    bit       m_valid;
    bit       m_ovf;
    int       m_idx;
    int       m_lg;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_prev = 0; m_valid = 0; m_ovf = 0; m_idx = 0; m_lg = 7;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"},   {7'd0, bus.valid}, {7'd0, m_valid});
        check({tag, ".idx"},     {5'd0, bus.idx},   8'(m_idx));
        check({tag, ".pending"}, bus.pending,       m_pend);
        check({tag, ".ovf"},     {7'd0, bus.ovf},   {7'd0, m_ovf});
    endtask

    // Advance one clock: model consumes the inputs seen at the edge, then the
    // DUT outputs are compared 1 time unit after the edge.
    task automatic tick(input string tag);
        bit [7:0] np;
        bit       set_ovf, hs, nv;
        int       ni, nlg, start, j;
        if (rst) begin
            @(posedge clk); #1;
            model_reset();
            check_all(tag);
            return;
        end
        hs = m_valid && bus.ack;
        set_ovf = 0;
        for (int i = 0; i < 8; i++) begin
            bit e, c;
            e = bus.req[i] && !m_prev[i];
            c = hs && (i == m_idx);
            if (e && m_pend[i] && !c) set_ovf = 1;
            np[i] = e ? 1'b1 : (c ? 1'b0 : m_pend[i]);
        end
        nv = m_valid; ni = m_idx; nlg = m_lg;
        if (m_valid) begin
            if (bus.ack) begin nv = 0; nlg = m_idx; end
        end else begin
`ifdef IRQ_ROUND_ROBIN_EN
            start = (m_lg + 1) % 8;
`else
            start = 0;
`endif
            for (int k = 0; k < 8; k++) begin
                j = (start + k) % 8;
                if (!nv && m_pend[j] && !bus.mask[j]) begin nv = 1; ni = j; end
            end
        end
        @(posedge clk); #1;
        m_ovf   = set_ovf ? 1'b1 : (bus.clr_ovf ? 1'b0 : m_ovf);
        m_pend  = np;
        m_prev  = bus.req;
        m_valid = nv; m_idx = ni; m_lg = nlg;
        check_all(tag);
    endtask

    initial begin
        bus.req = 0; bus.mask = 0; bus.ack = 0; bus.clr_ovf = 0;
        model_reset();
        tick("reset"); tick("reset");
        check("reset.pending", bus.pending, 8'h00);
        check("reset.valid", {7'd0, bus.valid}, 8'h00);
        #2 rst = 1'b0;

        // Single edge on bit 4: pending next cycle, valid the cycle after.
        bus.req = 8'h10; tick("t1.cap");
        check("t1.pending", bus.pending, 8'h10);
        bus.req = 8'h00; tick("t1.grant");
        check("t1.idx", {5'd0, bus.idx}, 8'd4);
        tick("t1.hold"); tick("t1.hold");
        bus.ack = 1; tick("t1.ack"); bus.ack = 0;
        check("t1.pending_clr", bus.pending, 8'h00);
        tick("t1.idle");

        // Two simultaneous edges, then a second burst.
        for (int b = 0; b < 2; b++) begin
            bus.req = 8'h82; tick("t2.cap"); bus.req = 8'h00;
            tick("t2.g1");
            bus.ack = 1; tick("t2.ack1"); bus.ack = 0;
            tick("t2.idle"); tick("t2.g2");
            bus.ack = 1; tick("t2.ack2"); bus.ack = 0;
            tick("t2.done");
        end

        // Masked candidate stays pending until unmasked.
        bus.mask = 8'h01; bus.req = 8'h01; tick("t3.cap"); bus.req = 8'h00;
        tick("t3.m"); tick("t3.m"); tick("t3.m");
        check("t3.pending", bus.pending, 8'h01);
        bus.mask = 8'h00; tick("t3.unmask"); tick("t3.grant");
        check("t3.idx", {5'd0, bus.idx}, 8'd0);
        bus.ack = 1; tick("t3.ack"); bus.ack = 0; tick("t3.idle");

        // Overflow on a held grant, clear, then edge coincident with ack.
        bus.req = 8'h08; tick("t4.cap"); bus.req = 8'h00; tick("t4.grant");
        tick("t4.hold");
        bus.req = 8'h08; tick("t4.ovf");
        check("t4.ovf_set", {7'd0, bus.ovf}, 8'h01);
        bus.req = 8'h00; bus.clr_ovf = 1; tick("t4.clr"); bus.clr_ovf = 0;
        check("t4.ovf_clr", {7'd0, bus.ovf}, 8'h00);
        bus.req = 8'h08; bus.ack = 1; tick("t4.ack_edge"); bus.ack = 0; bus.req = 8'h00;
        check("t4.pend3", {7'd0, bus.pending[3]}, 8'h01);
        tick("t4.idle"); tick("t4.regrant");
        bus.ack = 1; tick("t4.ack"); bus.ack = 0; tick("t4.done");

        // Async reset in the middle of a grant, req held across release.
        bus.req = 8'h28; tick("t5.cap"); bus.req = 8'h00; tick("t5.grant");
        bus.req = 8'h28; tick("t5.ovf");
        #2 rst = 1'b1; #1;
        model_reset();
        check_all("t5.async");
        tick("t5.rst"); tick("t5.rst");
        #2 rst = 1'b0;
        tick("t5.recap"); tick("t5.grant2"); tick("t5.hold");
        check("t5.pending", bus.pending, 8'h28);
        bus.req = 8'h00;
        bus.ack = 1; tick("t5.ack1"); bus.ack = 0; tick("t5.idle");
        tick("t5.g2"); bus.ack = 1; tick("t5.ack2"); bus.ack = 0; tick("t5.done");

        // ack while idle does nothing.
        bus.mask = 8'h04; bus.req = 8'h04; tick("t6.cap"); bus.req = 8'h00;
        bus.ack = 1; tick("t6.ack"); tick("t6.ack"); bus.ack = 0;
        check("t6.pending", bus.pending, 8'h04);
        bus.mask = 8'h00; tick("t6.unmask"); tick("t6.grant");
        bus.ack = 1; tick("t6.drain"); bus.ack = 0; tick("t6.done");

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            bus.req     = 8'($urandom) & 8'($urandom);
            bus.mask    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            bus.ack     = ($urandom_range(0, 2) == 0);
            bus.clr_ovf = ($urandom_range(0, 7) == 0);
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_prio_encoder_8x3.md
Name: irq_prio_encoder_8x3

Overview:
- 8-to-3 request encoder with a valid/ack handshake. It is the encode-side counterpart of the CPU's 3-to-8 one-hot select decoder.
- Captures rising edges on 8 request lines into a pending register.
- Selects the highest-priority unmasked pending request, presents its 3-bit index to the control unit, and holds it until acknowledged.
- Sits between the peripheral/interrupt lines and the CPU control FSM.

Parameters:
- N_REQ, 8, number of request lines; fixed at 8 to match the 3-bit index.
- IDX_W, 3, index width; log2(N_REQ).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request lines; level inputs, and only a 0->1 transition is an event.
- mask  input  8  1 = line excluded from selection (capture is unaffected).
- ack  input  1  consumer accepts the current idx; only meaningful while valid=1.
- clr_ovf  input  1  synchronous clear of ovf.
- idx  output  3  encoded index of the granted request.
- valid  output  1  idx is valid and stable.
- pending  output  8  current pending register.
- ovf  output  1  sticky flag: an edge arrived on a line that was already pending.

Behaviour:
- Reset (async, rst=1): pending=0, req_d (edge-detect flop)=0, idx=0, valid=0, ovf=0, state=IDLE.
- Edge capture:
  - edge[i] = req[i] & ~req_d[i]; req_d <= req every cycle.
  - pending[i] <= 1 on edge[i].
  - The first edge after reset counts if req is already 1 at reset release, because req_d resets to 0.
- Clear: on the cycle ack=1 while valid=1, pending[idx] <= 0.
  - If edge[idx] occurs in the same cycle, set wins: the bit stays 1 and ovf is not raised.
- ovf:
  - ovf <= 1 when edge[i] & pending[i] and that bit is not being cleared this cycle.
  - clr_ovf=1 clears ovf; a simultaneous set wins over clr_ovf.
- Selection: cand = pending & ~mask. Fixed priority, lowest index highest (bit 0 wins).
- FSM, two states:
  - IDLE: valid=0. If cand != 0, latch idx <= enc(cand) and go to GRANT.
  - GRANT: valid=1, idx frozen. Changes to mask or pending do not alter idx. On ack=1, clear pending[idx] and go to IDLE.
- Latency:
  - req edge sampled at cycle N -> pending visible at N+1 -> valid=1 at N+2.
  - After ack at cycle M, the next valid appears no earlier than M+2, leaving one IDLE cycle.
- ack while valid=0 is ignored and has no effect on pending.
- A granted line that becomes masked during GRANT is still delivered until ack.
- If all candidates are masked, the block stays in IDLE and pending bits persist.
- Reset mid-GRANT: outputs return to reset values immediately and the pending request is lost.
- idx holds its last value in IDLE; consumers qualify it with valid.

Optional Feature:
- Macro: IRQ_ROUND_ROBIN_EN.
- Defined:
  - Rotating priority. A 3-bit last-grant pointer lg resets to 7.
  - Search starts at (lg+1) mod 8 and wraps 7->0.
  - lg <= idx on each ack handshake.
- Undefined:
  - Fixed priority, bit 0 highest. No pointer register is generated.

Decomposition:
- Package irq_enc_pkg:
  - constants N_REQ=8, IDX_W=3.
  - state typedef {IDLE, GRANT}.
- Sub-module prio_enc_8x3: combinational.
  - Inputs: 8-bit vector and 3-bit start position.
  - Outputs: 3-bit index of the first set bit at or after start (wrapping), plus an any flag.
  - Fixed-priority mode ties start to 0.
- The top level holds the edge detect, pending register, FSM and ovf.

Test Plan:
- Reset, then pulse req=8'h00->8'h10 at cycle 0 -> pending=8'h10 at cycle 1; valid=1 and idx=4 at cycle 2; idx held until ack; pending=0 after ack.
- Simultaneous edges req=8'h82, mask=0 -> idx=1 first. After ack, idx=7 two cycles later. Round-robin build: same result, then a second 8'h82 burst grants 7 before 1 only if lg=1.
- mask=8'h01 with req edge on bit 0 -> no valid, pending=8'h01. Drop mask -> valid with idx=0 two cycles later.
- Hold GRANT on idx=3 with no ack, pulse req[3] again -> ovf=1 and pending[3] stays 1. clr_ovf -> ovf=0. Edge on bit 3 coincident with ack -> pending[3] remains 1 and ovf stays 0.
- Assert rst mid-GRANT with pending=8'h28 -> valid, idx, pending and ovf drop to 0 in the same cycle without a clock edge. req held high does not re-trigger after release until req_d catches up, i.e. exactly one capture.
- ack while valid=0, with pending=8'h04 and mask=8'h04 -> pending unchanged at 8'h04.
